// File: rtl/iter_muldiv_unit.sv
// Iterative unsigned multiply/divide unit: one bit per cycle, fixed latency,
// with a single-cycle register-file write-back request on completion.
module iter_muldiv_unit #(
  parameter int DATA_WIDTH      = 32,
  parameter int REG_INDEX_WIDTH = 5,
  parameter int CNT_WIDTH       = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [1:0]                 op,
  input  logic [DATA_WIDTH-1:0]      operand_a,
  input  logic [DATA_WIDTH-1:0]      operand_b,
  input  logic [REG_INDEX_WIDTH-1:0] dest_index,
  output logic                       busy,
  output logic                       done,
  output logic [DATA_WIDTH-1:0]      result,
  output logic                       wr_en,
  output logic [REG_INDEX_WIDTH-1:0] wr_reg_index,
  output logic [DATA_WIDTH-1:0]      wr_reg_data
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(DATA_WIDTH - 1);

  state_t                     state;
  logic [1:0]                 op_q;
  logic [REG_INDEX_WIDTH-1:0] idx_q;
  logic [CNT_WIDTH-1:0]       cnt;
  // opnd is the multiplicand for MUL* and the divisor for DIV*; {hi,lo} is
  // the product register, or {partial remainder, dividend/quotient}.
  logic [DATA_WIDTH-1:0]      opnd;
  logic [DATA_WIDTH-1:0]      hi;
  logic [DATA_WIDTH-1:0]      lo;

  logic [DATA_WIDTH:0]        mul_sum;
  logic [DATA_WIDTH:0]        div_shift;
  logic [DATA_WIDTH:0]        div_diff;
  logic [DATA_WIDTH-1:0]      nxt_hi;
  logic [DATA_WIDTH-1:0]      nxt_lo;

  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    div_shift = {hi, lo[DATA_WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    nxt_hi    = hi;
    nxt_lo    = lo;
    if (op_q[1]) begin
      // Borrow out of the (DATA_WIDTH+1)-bit subtract means remainder < divisor.
      if (!div_diff[DATA_WIDTH]) begin
        nxt_hi = div_diff[DATA_WIDTH-1:0];
        nxt_lo = {lo[DATA_WIDTH-2:0], 1'b1};
      end else begin
        nxt_hi = div_shift[DATA_WIDTH-1:0];
        nxt_lo = {lo[DATA_WIDTH-2:0], 1'b0};
      end
    end else begin
      nxt_hi = mul_sum[DATA_WIDTH:1];
      nxt_lo = {mul_sum[0], lo[DATA_WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op_q   <= '0;
      idx_q  <= '0;
      cnt    <= '0;
      opnd   <= '0;
      hi     <= '0;
      lo     <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q  <= op;
            idx_q <= dest_index;
            cnt   <= '0;
            opnd  <= op[1] ? operand_b : operand_a;
            hi    <= '0;
            lo    <= op[1] ? operand_a : operand_b;
            state <= CALC;
          end
        end
        CALC: begin
          hi  <= nxt_hi;
          lo  <= nxt_lo;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_ITER) begin
            // MULHU/REMU live in the upper half, MUL/DIVU in the lower half.
            result <= op_q[0] ? nxt_hi : nxt_lo;
            state  <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy         = (state != IDLE);
  assign done         = (state == DONE);
  assign wr_en        = done && (idx_q != '0);
  assign wr_reg_index = idx_q;
  assign wr_reg_data  = result;

endmodule
